// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back, write-allocate data cache (32 lines x 4 words x 16 bits).
// States: IDLE, COMPARE, WB0-WB3 (evict dirty victim), RD0-RD3 (issue refill reads), WAIT0-WAIT1 (refill tail).
module dcache_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_data_in,
    output logic [15:0] o_data_out,
    output logic        o_done,
    output logic        o_stall,
    output logic        o_cache_hit,
    output logic        o_err,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_data_out,
    input  logic [15:0] i_mem_data_in
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_COMPARE = 4'd1,
        S_WB0     = 4'd4,
        S_WB1     = 4'd5,
        S_WB2     = 4'd6,
        S_WB3     = 4'd7,
        S_RD0     = 4'd8,
        S_RD1     = 4'd9,
        S_RD2     = 4'd10,
        S_RD3     = 4'd11,
        S_WAIT0   = 4'd12,
        S_WAIT1   = 4'd13
    } state_t;

    state_t      r_state;

    logic [31:0] r_valid;
    logic [31:0] r_dirty;
    logic [7:0]  r_tag  [32];
    logic [15:0] r_data [32][4];

    logic        r_req_rd;
    logic [7:0]  r_req_tag;
    logic [4:0]  r_req_idx;
    logic [1:0]  r_req_word;
    logic [15:0] r_req_data;

    logic        r_done;
    logic        r_hit;
    logic        r_stall;
    logic [15:0] r_data_out;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_data_out;

    logic [7:0]  w_in_tag;
    logic [4:0]  w_in_idx;
    logic [1:0]  w_in_word;
    logic        w_idle;
    logic        w_legal;
    logic        w_err;
    logic        w_lookup_hit;
    logic        w_victim_dirty;
    logic [7:0]  w_victim_tag;
    logic [3:0]  w_state_bits;
    logic [1:0]  w_k_next;
    logic [15:0] w_refill_word;

    assign w_in_tag       = i_addr[15:8];
    assign w_in_idx       = i_addr[7:3];
    assign w_in_word      = i_addr[2:1];
    assign w_idle         = (r_state == S_IDLE);
    assign w_legal        = w_idle && (i_rd ^ i_wr) && !i_addr[0];
    assign w_err          = !i_rst && w_idle && ((i_rd & i_wr) | ((i_rd ^ i_wr) & i_addr[0]));
    assign w_lookup_hit   = r_valid[w_in_idx] && (r_tag[w_in_idx] == w_in_tag);
    assign w_victim_dirty = r_valid[r_req_idx] & r_dirty[r_req_idx];
    assign w_victim_tag   = r_tag[r_req_idx];
    assign w_state_bits   = r_state;
    assign w_k_next       = w_state_bits[1:0] + 2'd1;

    // Word 3 is still on the memory bus in WAIT1, so a load of it bypasses the array.
    assign w_refill_word  = (r_req_word == 2'd3) ? i_mem_data_in : r_data[r_req_idx][r_req_word];

    // Outputs are registered for the state being entered; the tag lookup is done as the
    // request is latched, since the array cannot change before COMPARE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_valid        <= '0;
            r_dirty        <= '0;
            r_done         <= 1'b0;
            r_hit          <= 1'b0;
            r_stall        <= 1'b0;
            r_data_out     <= '0;
            r_mem_rd       <= 1'b0;
            r_mem_wr       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_data_out <= '0;
        end else begin
            r_done         <= 1'b0;
            r_hit          <= 1'b0;
            r_mem_rd       <= 1'b0;
            r_mem_wr       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_data_out <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_legal) begin
                        r_req_rd   <= i_rd;
                        r_req_tag  <= w_in_tag;
                        r_req_idx  <= w_in_idx;
                        r_req_word <= w_in_word;
                        r_req_data <= i_data_in;
                        r_stall    <= 1'b1;
                        r_state    <= S_COMPARE;
                        if (w_lookup_hit) begin
                            r_done <= 1'b1;
                            r_hit  <= 1'b1;
                            if (i_rd) begin
                                r_data_out <= r_data[w_in_idx][w_in_word];
                            end else begin
                                r_data[w_in_idx][w_in_word] <= i_data_in;
                                r_dirty[w_in_idx]           <= 1'b1;
                            end
                        end
                    end
                end
                S_COMPARE: begin
                    if (r_done) begin
                        r_state <= S_IDLE;
                        r_stall <= 1'b0;
                    end else if (w_victim_dirty) begin
                        r_state        <= S_WB0;
                        r_mem_wr       <= 1'b1;
                        r_mem_addr     <= {w_victim_tag, r_req_idx, 2'd0, 1'b0};
                        r_mem_data_out <= r_data[r_req_idx][0];
                    end else begin
                        r_state    <= S_RD0;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= {r_req_tag, r_req_idx, 2'd0, 1'b0};
                    end
                end
                S_WB0, S_WB1, S_WB2: begin
                    r_state        <= state_t'(w_state_bits + 4'd1);
                    r_mem_wr       <= 1'b1;
                    r_mem_addr     <= {w_victim_tag, r_req_idx, w_k_next, 1'b0};
                    r_mem_data_out <= r_data[r_req_idx][w_k_next];
                end
                S_WB3: begin
                    r_state    <= S_RD0;
                    r_mem_rd   <= 1'b1;
                    r_mem_addr <= {r_req_tag, r_req_idx, 2'd0, 1'b0};
                end
                S_RD0, S_RD1: begin
                    r_state    <= state_t'(w_state_bits + 4'd1);
                    r_mem_rd   <= 1'b1;
                    r_mem_addr <= {r_req_tag, r_req_idx, w_k_next, 1'b0};
                end
                S_RD2: begin
                    r_data[r_req_idx][0] <= i_mem_data_in;
                    r_state              <= S_RD3;
                    r_mem_rd             <= 1'b1;
                    r_mem_addr           <= {r_req_tag, r_req_idx, 2'd3, 1'b0};
                end
                S_RD3: begin
                    r_data[r_req_idx][1] <= i_mem_data_in;
                    r_state              <= S_WAIT0;
                end
                S_WAIT0: begin
                    r_data[r_req_idx][2] <= i_mem_data_in;
                    r_state              <= S_WAIT1;
                end
                S_WAIT1: begin
                    r_data[r_req_idx][3] <= i_mem_data_in;
                    r_tag[r_req_idx]     <= r_req_tag;
                    r_valid[r_req_idx]   <= 1'b1;
                    r_dirty[r_req_idx]   <= 1'b0;
                    r_state              <= S_COMPARE;
                    r_done               <= 1'b1;
                    // A store to word 3 must override the word captured in this same cycle.
                    if (r_req_rd) begin
                        r_data_out <= w_refill_word;
                    end else begin
                        r_data[r_req_idx][r_req_word] <= r_req_data;
                        r_dirty[r_req_idx]            <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    assign o_data_out     = r_data_out;
    assign o_done         = r_done | w_err;
    assign o_stall        = r_stall;
    assign o_cache_hit    = r_hit;
    assign o_err          = w_err;
    assign o_mem_rd       = r_mem_rd;
    assign o_mem_wr       = r_mem_wr;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_data_out = r_mem_data_out;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: fixed-latency memory model plus a transaction-level cache model that
// predicts every output cycle by cycle, with literal latency/data checks on directed requests.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst, rd, wr;
    logic [15:0] addr, din;
    logic [15:0] dout, mem_addr, mem_dout, mem_din;
    logic        done, stall, hit, err, mem_rd, mem_wr;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_rd(rd), .i_wr(wr), .i_addr(addr), .i_data_in(din),
        .o_data_out(dout), .o_done(done), .o_stall(stall), .o_cache_hit(hit), .o_err(err),
        .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .o_mem_addr(mem_addr),
        .o_mem_data_out(mem_dout), .i_mem_data_in(mem_din)
    );

    // Main memory: read data appears two cycles after the issue cycle.
    logic [15:0] mem [32768];
    logic        p1_v = 1'b0, p2_v = 1'b0;
    logic [14:0] p1_a = '0, p2_a = '0;
    always @(posedge clk) begin
        p1_v <= mem_rd;
        p1_a <= mem_addr[15:1];
        p2_v <= p1_v;
        p2_a <= p1_a;
        if (mem_wr) mem[mem_addr[15:1]] = mem_dout;
    end
    assign mem_din = p2_v ? mem[p2_a] : 16'h0000;

    typedef struct packed {
        logic        done, stall, hit, err, mrd, mwr;
        logic [15:0] maddr, mdo, dout;
    } obs_t;

    obs_t  exp_q[$];
    obs_t  plan[$];
    int    n_cmp = 0, n_bad = 0;
    string step = "reset";

    // Reference cache and memory contents at transaction level.
    logic        mv [32];
    logic        md [32];
    logic [7:0]  mt [32];
    logic [15:0] mdat [32][4];
    logic [15:0] mmem [32768];
    logic [15:0] exp_dout;

    int          g_lat;
    logic [15:0] g_dout;
    logic        g_hit, g_err;

    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {done, stall, hit, err, mem_rd, mem_wr, mem_addr, mem_dout, dout};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL cycle [%s] got done=%b stall=%b hit=%b err=%b mrd=%b mwr=%b maddr=%h mdo=%h dout=%h / need done=%b stall=%b hit=%b err=%b mrd=%b mwr=%b maddr=%h mdo=%h dout=%h",
                         step, a.done, a.stall, a.hit, a.err, a.mrd, a.mwr, a.maddr, a.mdo, a.dout,
                         e.done, e.stall, e.hit, e.err, e.mrd, e.mwr, e.maddr, e.mdo, e.dout);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h need %h", nm, act, expv);
        end
    endtask

    function automatic obs_t idle_obs();
        obs_t e;
        e = '0;
        e.dout = exp_dout;
        return e;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
        exp_dout = 16'h0000;
    endfunction

    // Builds the expected per-cycle outputs of one request, starting with the request cycle.
    task automatic build(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        obs_t       e;
        logic [7:0] tg;
        logic [4:0] ix;
        logic [1:0] wd;
        logic       first;
        plan.delete();
        e = idle_obs();
        if ((r & w) | ((r | w) & a[0])) begin
            e.err  = 1'b1;
            e.done = 1'b1;
            plan.push_back(e);
            return;
        end
        plan.push_back(e);
        tg    = a[15:8];
        ix    = a[7:3];
        wd    = a[2:1];
        first = mv[ix] && (mt[ix] == tg);
        if (!first) begin
            e = idle_obs(); e.stall = 1'b1;
            plan.push_back(e);
            if (mv[ix] && md[ix]) begin
                for (int k = 0; k < 4; k++) begin
                    e = idle_obs(); e.stall = 1'b1; e.mwr = 1'b1;
                    e.maddr = {mt[ix], ix, 2'(k), 1'b0};
                    e.mdo   = mdat[ix][k];
                    plan.push_back(e);
                    mmem[{mt[ix], ix, 2'(k)}] = mdat[ix][k];
                end
            end
            for (int k = 0; k < 4; k++) begin
                e = idle_obs(); e.stall = 1'b1; e.mrd = 1'b1;
                e.maddr = {tg, ix, 2'(k), 1'b0};
                plan.push_back(e);
                mdat[ix][k] = mmem[{tg, ix, 2'(k)}];
            end
            for (int k = 0; k < 2; k++) begin
                e = idle_obs(); e.stall = 1'b1;
                plan.push_back(e);
            end
            mt[ix] = tg;
            mv[ix] = 1'b1;
            md[ix] = 1'b0;
        end
        if (r) begin
            exp_dout = mdat[ix][wd];
        end else begin
            mdat[ix][wd] = d;
            md[ix]       = 1'b1;
        end
        e = idle_obs(); e.stall = 1'b1; e.done = 1'b1; e.hit = first;
        plan.push_back(e);
    endtask

    // Issues one request; rst_at >= 0 asserts reset in that cycle of the request instead of completing.
    task automatic do_req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                          input int rst_at);
        @(posedge clk); #1;
        rd = r; wr = w; addr = a; din = d;
        build(r, w, a, d);
        for (int i = 0; i < plan.size(); i++)
            if (rst_at < 0 || i <= rst_at) exp_q.push_back(plan[i]);
        g_lat = -1; g_dout = '0; g_hit = 1'b0; g_err = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                g_lat = c; g_dout = dout; g_hit = hit; g_err = err;
                break;
            end
            @(posedge clk); #1;
            rd = 1'b0; wr = 1'b0;
            if (rst_at >= 0 && c + 1 == rst_at) begin
                rst = 1'b1;
                break;
            end
        end
        #1;
        rd = 1'b0; wr = 1'b0;
        if (rst_at >= 0) begin
            @(posedge clk); #1;
            model_reset();
            exp_q.push_back(idle_obs());
            rst = 1'b0;
            @(negedge clk);
        end else if (g_lat < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: no done within 40 cycles", step);
        end
    endtask

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
        for (int i = 0; i < 32768; i++) begin
            mem[i]  = 16'(i * 7) ^ 16'h3C00;
            mmem[i] = 16'(i * 7) ^ 16'h3C00;
        end
        mem[8]  = 16'hAAAA;
        mmem[8] = 16'hAAAA;
        model_reset();

        @(posedge clk); #1;
        exp_q.push_back(idle_obs());
        @(posedge clk); #1;
        rst = 1'b0;

        step = "load miss 0010";
        do_req(1'b1, 1'b0, 16'h0010, 16'h0, -1);
        chk("lat_0010_miss", 32'(g_lat), 32'd8);
        chk("dout_0010_miss", 32'(g_dout), 32'hAAAA);
        chk("hit_0010_miss", 32'(g_hit), 32'd0);

        step = "load hit 0010";
        do_req(1'b1, 1'b0, 16'h0010, 16'h0, -1);
        chk("lat_0010_hit", 32'(g_lat), 32'd1);
        chk("hit_0010_hit", 32'(g_hit), 32'd1);
        chk("dout_0010_hit", 32'(g_dout), 32'hAAAA);

        step = "store hit 0012";
        do_req(1'b0, 1'b1, 16'h0012, 16'h1234, -1);
        chk("lat_0012_store", 32'(g_lat), 32'd1);
        chk("hit_0012_store", 32'(g_hit), 32'd1);

        step = "load dirty miss 0112";
        do_req(1'b1, 1'b0, 16'h0112, 16'h0, -1);
        chk("lat_0112_dirty", 32'(g_lat), 32'd12);
        chk("hit_0112_dirty", 32'(g_hit), 32'd0);
        chk("dout_0112", 32'(g_dout), 32'h3FBF);
        chk("wb_mem_0012", 32'(mem[9]), 32'h1234);

        step = "store miss 2006";
        do_req(1'b0, 1'b1, 16'h2006, 16'h5555, -1);
        chk("lat_2006_store", 32'(g_lat), 32'd8);
        step = "load hit 2006";
        do_req(1'b1, 1'b0, 16'h2006, 16'h0, -1);
        chk("lat_2006_load", 32'(g_lat), 32'd1);
        chk("dout_2006", 32'(g_dout), 32'h5555);

        step = "illegal rd+wr";
        do_req(1'b1, 1'b1, 16'h0010, 16'h0, -1);
        chk("lat_illegal_rw", 32'(g_lat), 32'd0);
        chk("err_illegal_rw", 32'(g_err), 32'd1);
        step = "illegal odd addr";
        do_req(1'b1, 1'b0, 16'h0011, 16'h0, -1);
        chk("lat_illegal_odd", 32'(g_lat), 32'd0);
        chk("err_illegal_odd", 32'(g_err), 32'd1);
        step = "load hit 0112 after illegal";
        do_req(1'b1, 1'b0, 16'h0112, 16'h0, -1);
        chk("lat_0112_hit", 32'(g_lat), 32'd1);

        step = "store miss word3 3016";
        do_req(1'b0, 1'b1, 16'h3016, 16'hBEEF, -1);
        chk("lat_3016_store", 32'(g_lat), 32'd8);
        step = "load hit 3016";
        do_req(1'b1, 1'b0, 16'h3016, 16'h0, -1);
        chk("dout_3016_hit", 32'(g_dout), 32'hBEEF);
        step = "load hit 3010";
        do_req(1'b1, 1'b0, 16'h3010, 16'h0, -1);
        step = "load miss word3 4036";
        do_req(1'b1, 1'b0, 16'h4036, 16'h0, -1);
        step = "load dirty miss 5010";
        do_req(1'b1, 1'b0, 16'h5010, 16'h0, -1);
        chk("lat_5010_dirty", 32'(g_lat), 32'd12);
        step = "reload 3016 from memory";
        do_req(1'b1, 1'b0, 16'h3016, 16'h0, -1);
        chk("lat_3016_reload", 32'(g_lat), 32'd8);
        chk("dout_3016_reload", 32'(g_dout), 32'hBEEF);

        step = "reset during RD2";
        do_req(1'b1, 1'b0, 16'h6028, 16'h0, 4);
        step = "reload 6028 after reset";
        do_req(1'b1, 1'b0, 16'h6028, 16'h0, -1);
        chk("lat_6028_after_rst", 32'(g_lat), 32'd8);
        chk("hit_6028_after_rst", 32'(g_hit), 32'd0);
        step = "reload 0010 after reset";
        do_req(1'b1, 1'b0, 16'h0010, 16'h0, -1);
        chk("lat_0010_after_rst", 32'(g_lat), 32'd8);
        chk("dout_0010_after_rst", 32'(g_dout), 32'hAAAA);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d expected cycles left unchecked", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache with integrated controller FSM, placed between the pipeline's memory stage and a fixed-latency four-bank main memory. The memory stage issues one load or store at a time. The cache reports completion with a one-cycle `done` pulse and holds `stall` high while busy. Misses evict dirty lines word by word, then refill the four-word line from memory.

## Interface
Parameters: none. Geometry is fixed: 32 lines × 4 words × 16 bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rd` in 1: load request; sampled only in IDLE.
- `wr` in 1: store request; sampled only in IDLE.
- `addr` in 16: byte address; tag = `addr[15:8]`, index = `addr[7:3]`, word = `addr[2:1]`; `addr[0]` must be 0.
- `dataIn` in 16: store data.
- `dataOut` out 16: load data, valid in the `done` cycle of a load.
- `done` out 1: one-cycle completion pulse.
- `stall` out 1: high in every state except IDLE.
- `cacheHit` out 1: high with `done` when the first lookup hit.
- `err` out 1: one-cycle pulse on an illegal request.
- `memRd` out 1: main-memory read issue.
- `memWr` out 1: main-memory write issue.
- `memAddr` out 16: main-memory word address (byte address, bit 0 = 0).
- `memDataOut` out 16: main-memory write data.
- `memDataIn` in 16: main-memory read data; valid exactly 2 cycles after the `memRd` issue cycle.

## Operation
- Storage per line: valid bit, dirty bit, 8-bit tag, 4 × 16-bit words. `rst` clears all valid and dirty bits. Data and tag contents are don't-care after reset.
- IDLE
  - A request (`rd` xor `wr`) with `addr[0]`=0 latches `addr`, `dataIn` and the op type, then moves to COMPARE.
  - `rd`&`wr`, or `addr[0]`=1: pulse `err` and `done` in the same cycle, stay in IDLE, change nothing.
- COMPARE: hit = valid & tag match.
  - Hit on a load: drive `dataOut` with the word.
  - Hit on a store: write the word and set dirty.
  - In both hit cases: pulse `done`, drive `cacheHit` = 1 if this is the first compare of the request (0 if reached after a refill), return to IDLE.
  - Miss with victim valid & dirty: go to WB0.
  - Miss otherwise: go to RD0.
- WB0..WB3
  - `memWr`=1.
  - `memAddr` = {victim tag, index, k, 1'b0}.
  - `memDataOut` = victim word k.
  - One word per cycle, then RD0.
- RD0..RD3
  - `memRd`=1, `memAddr` = {req tag, index, k, 1'b0}.
  - In RD2 and RD3, capture `memDataIn` into words 0 and 1.
- WAIT0, WAIT1
  - Capture words 2 and 3.
  - In WAIT1: set tag, valid=1, dirty=0, then go to COMPARE, which now hits and completes the request.
- Memory never stalls. Exactly one of `memRd`/`memWr` may be high per cycle, and neither is high outside WB/RD states.
- `memAddr` and `memDataOut` are 0 outside WB/RD states.
- `dataOut` holds its last load value between loads.

## Timing
- Reset values: `dataOut`=0, all other outputs 0; state IDLE.
- Request sampled at edge N:
  - hit: `done` in cycle N+1;
  - clean miss: `done` in N+8;
  - dirty miss: `done` in N+12.
- `stall`=1 from cycle N+1 through the `done` cycle inclusive. Inputs are ignored while `stall`=1.
- Illegal request: `err`=`done`=1 in cycle N, with `stall`=0.
- `rst` asserted in any state: next cycle is IDLE with all outputs 0. In-flight memory writes are abandoned and partial refills are discarded; the line is not left valid.
- Back-to-back: a new request may be presented in the cycle after `done`.

## Test plan
- After reset, load 0x0010: 4 `memRd` to 0x0010/12/14/16; memory returns 0xAAAA at 0x0010; `done` at N+8 with `dataOut`=0xAAAA and `cacheHit`=0. Repeat the load: `done` at N+1 with `cacheHit`=1.
- Store 0x1234 to 0x0012 (hit) → `done` at N+1. Then load 0x0112 (same index, tag 0x01) → 4 `memWr` to 0x0010..0x0016 carrying 0x0012=0x1234, then 4 `memRd`; `done` at N+12.
- Store miss to 0x2006 on an empty line → refill, then write 0x5555. A following load of 0x2006 hits and returns 0x5555.
- `rd`=`wr`=1, and separately `addr`=0x0011 → `err`=`done`=1 that cycle, no memory activity, state stays IDLE.
- Assert `rst` during RD2 of a miss → all outputs 0 next cycle. A reload of the same address misses again (8-cycle latency).
